fifo_arbiter: RTL and testbench

FIFO_ARBITER -- requirements
Module: fifo_arbiter

---
 rtl/fifo_arb_pkg.sv | 35 +++
 rtl/fifo_arbiter_if.sv | 39 +++
 rtl/fifo_arbiter_rr_pick3.sv | 43 ++++
 rtl/fifo_arbiter.sv | 96 +++++++++
 tb/tb_fifo_arbiter.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the two-producer / one-consumer FIFO arbiter.
package fifo_arb_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int DEPTH_DEF   = 8;
  localparam int COUNT_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_ISSUE = 2'd1,
    RD_ISSUE = 2'd2,
    RD_DATA  = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    REQ_W0 = 2'd0,
    REQ_W1 = 2'd1,
    REQ_RD = 2'd2
  } req_idx_e;

  // The pointer always lands on the requester that follows the winner.
  function automatic req_idx_e next_ptr(input logic [2:0] winner, input req_idx_e cur);
    req_idx_e nxt;
    nxt = cur;
    if (winner[0]) begin
      nxt = REQ_W1;
    end else if (winner[1]) begin
      nxt = REQ_RD;
    end else if (winner[2]) begin
      nxt = REQ_W0;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/fifo_arbiter_if.sv
// Requester, consumer and FIFO-side signals of the arbiter; master is the arbiter side.
interface fifo_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int COUNT_W = COUNT_W_DEF
);

  logic               wr_req0;
  logic               wr_req1;
  logic [DATA_W-1:0]  wr_data0;
  logic [DATA_W-1:0]  wr_data1;
  logic               rd_req;
  logic [COUNT_W-1:0] data_count;
  logic [DATA_W-1:0]  fifo_dout;

  logic               fifo_wr_en;
  logic               fifo_rd_en;
  logic [DATA_W-1:0]  fifo_din;
  logic               wr_gnt0;
  logic               wr_gnt1;
  logic               rd_gnt;
  logic               rd_valid;
  logic [DATA_W-1:0]  rd_data;
  logic               busy;

  modport master (
    input  wr_req0, wr_req1, wr_data0, wr_data1, rd_req, data_count, fifo_dout,
    output fifo_wr_en, fifo_rd_en, fifo_din, wr_gnt0, wr_gnt1, rd_gnt,
           rd_valid, rd_data, busy
  );

  modport slave (
    output wr_req0, wr_req1, wr_data0, wr_data1, rd_req, data_count, fifo_dout,
    input  fifo_wr_en, fifo_rd_en, fifo_din, wr_gnt0, wr_gnt1, rd_gnt,
           rd_valid, rd_data, busy
  );

endinterface

// File: rtl/fifo_arbiter_rr_pick3.sv
// Combinational 3-way round-robin picker: one-hot winner, search starts at the pointer.
module rr_pick3
  import fifo_arb_pkg::*;
(
  input  logic [2:0] eligible_i,
  input  req_idx_e   ptr_i,
  output logic [2:0] winner_o
);

  always_comb begin
    winner_o = 3'b000;
    case (ptr_i)
      REQ_W1: begin
        if (eligible_i[1]) begin
          winner_o = 3'b010;
        end else if (eligible_i[2]) begin
          winner_o = 3'b100;
        end else if (eligible_i[0]) begin
          winner_o = 3'b001;
        end
      end
      REQ_RD: begin
        if (eligible_i[2]) begin
          winner_o = 3'b100;
        end else if (eligible_i[0]) begin
          winner_o = 3'b001;
        end else if (eligible_i[1]) begin
          winner_o = 3'b010;
        end
      end
      default: begin
        if (eligible_i[0]) begin
          winner_o = 3'b001;
        end else if (eligible_i[1]) begin
          winner_o = 3'b010;
        end else if (eligible_i[2]) begin
          winner_o = 3'b100;
        end
      end
    endcase
  end

endmodule

// File: rtl/fifo_arbiter.sv
// Arbitrates two producers and one consumer onto a single-port FIFO.
// Every output is a decode of registered state, so reset clears them without a clock.
module fifo_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int COUNT_W = COUNT_W_DEF
) (
  input logic            clk,
  input logic            reset,
  fifo_arbiter_if.master bus
);

  arb_state_e        state_q, state_d;
  req_idx_e          ptr_q, ptr_d;
  logic              wsel_q, wsel_d;
  logic [DATA_W-1:0] fifo_din_q, fifo_din_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  logic [COUNT_W-1:0] count;
  logic               full;
  logic               empty;
  logic [2:0]         eligible;
  logic [2:0]         winner;

  // Any occupancy at or beyond DEPTH counts as full.
  assign count    = bus.data_count;
  assign full     = (int'(count) >= DEPTH);
  assign empty    = (count == '0);
  assign eligible = {bus.rd_req & ~empty, bus.wr_req1 & ~full, bus.wr_req0 & ~full};

  rr_pick3 u_pick (
    .eligible_i (eligible),
    .ptr_i      (ptr_q),
    .winner_o   (winner)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    wsel_d     = wsel_q;
    fifo_din_d = fifo_din_q;
    rd_data_d  = rd_data_q;
    case (state_q)
      IDLE: begin
        ptr_d = next_ptr(winner, ptr_q);
        if (winner[0]) begin
          state_d    = WR_ISSUE;
          wsel_d     = 1'b0;
          fifo_din_d = bus.wr_data0;
        end else if (winner[1]) begin
          state_d    = WR_ISSUE;
          wsel_d     = 1'b1;
          fifo_din_d = bus.wr_data1;
        end else if (winner[2]) begin
          state_d    = RD_ISSUE;
        end
      end
      WR_ISSUE: state_d = IDLE;
      RD_ISSUE: begin
        state_d   = RD_DATA;
        rd_data_d = bus.fifo_dout;
      end
      RD_DATA:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= REQ_W0;
      wsel_q     <= 1'b0;
      fifo_din_q <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      wsel_q     <= wsel_d;
      fifo_din_q <= fifo_din_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign bus.fifo_wr_en = (state_q == WR_ISSUE);
  assign bus.wr_gnt0    = (state_q == WR_ISSUE) && !wsel_q;
  assign bus.wr_gnt1    = (state_q == WR_ISSUE) && wsel_q;
  assign bus.fifo_rd_en = (state_q == RD_ISSUE);
  assign bus.rd_gnt     = (state_q == RD_ISSUE);
  assign bus.rd_valid   = (state_q == RD_DATA);
  assign bus.busy       = (state_q != IDLE);
  assign bus.fifo_din   = fifo_din_q;
  assign bus.rd_data    = rd_data_q;

endmodule

// File: tb/tb_fifo_arbiter.sv
// Directed bench for fifo_arbiter: inputs change and outputs are checked on the falling edge.
module tb_fifo_arbiter;
  import fifo_arb_pkg::*;

  logic clk;
  logic reset;
  int   testsRun    = 0;
  int   testsFailed = 0;

  fifo_arbiter_if #(.DATA_W(32), .COUNT_W(4)) bus ();

  fifo_arbiter #(.DATA_W(32), .DEPTH(8), .COUNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic w0, input logic w1, input logic r,
                               input logic [3:0] dc, input logic [31:0] d0,
                               input logic [31:0] d1, input logic [31:0] dout);
    bus.wr_req0    = w0;
    bus.wr_req1    = w1;
    bus.rd_req     = r;
    bus.data_count = dc;
    bus.wr_data0   = d0;
    bus.wr_data1   = d1;
    bus.fifo_dout  = dout;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic checkFlag(input string tag, input logic observed, input logic expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.busy && n < 10);
    checkFlag(tag, bus.busy, 1'b0);
  endtask

  initial begin
    int grantSeq[$];
    int expSeq[4];
    int rdCount;
    int wrCount;
    expSeq = '{0, 1, 2, 0};

    reset = 1'b1;
    applyStimulus(0, 0, 0, 4'd0, 32'h0, 32'h0, 32'h0);
    #2;
    checkFlag("rst_busy", bus.busy, 1'b0);
    checkFlag("rst_wr_en", bus.fifo_wr_en, 1'b0);
    checkFlag("rst_rd_en", bus.fifo_rd_en, 1'b0);
    checkFlag("rst_gnt0", bus.wr_gnt0, 1'b0);
    checkFlag("rst_gnt1", bus.wr_gnt1, 1'b0);
    checkFlag("rst_rd_gnt", bus.rd_gnt, 1'b0);
    checkFlag("rst_rd_valid", bus.rd_valid, 1'b0);
    checkOutput("rst_din", bus.fifo_din, 32'h0);
    checkOutput("rst_rd_data", bus.rd_data, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Single write from producer 0
    applyStimulus(1, 0, 0, 4'd0, 32'hA5A5A5A5, 32'h0, 32'h0);
    @(negedge clk);
    checkFlag("wr_en", bus.fifo_wr_en, 1'b1);
    checkOutput("wr_din", bus.fifo_din, 32'hA5A5A5A5);
    checkFlag("wr_gnt0", bus.wr_gnt0, 1'b1);
    checkFlag("wr_gnt1_low", bus.wr_gnt1, 1'b0);
    checkFlag("wr_busy", bus.busy, 1'b1);
    checkFlag("wr_rd_en_low", bus.fifo_rd_en, 1'b0);
    applyStimulus(0, 0, 0, 4'd1, 32'hA5A5A5A5, 32'h0, 32'h0);
    @(negedge clk);
    checkFlag("wr_en_drop", bus.fifo_wr_en, 1'b0);
    checkFlag("wr_gnt0_drop", bus.wr_gnt0, 1'b0);
    checkFlag("wr_idle", bus.busy, 1'b0);
    checkOutput("wr_din_hold", bus.fifo_din, 32'hA5A5A5A5);

    // Full FIFO blocks both writers
    applyStimulus(1, 1, 0, 4'd8, 32'h1, 32'h2, 32'h0);
    repeat (3) begin
      @(negedge clk);
      checkFlag("full_busy", bus.busy, 1'b0);
      checkFlag("full_wr_en", bus.fifo_wr_en, 1'b0);
    end

    // Empty FIFO blocks the read until a write lands
    applyStimulus(0, 0, 1, 4'd0, 32'h0, 32'h0, 32'h0);
    repeat (2) begin
      @(negedge clk);
      checkFlag("empty_rd_en", bus.fifo_rd_en, 1'b0);
      checkFlag("empty_busy", bus.busy, 1'b0);
    end
    applyStimulus(0, 1, 1, 4'd0, 32'h0, 32'hDEADBEEF, 32'h0);
    @(negedge clk);
    checkFlag("empty_wr_gnt1", bus.wr_gnt1, 1'b1);
    checkOutput("empty_wr_din", bus.fifo_din, 32'hDEADBEEF);
    applyStimulus(0, 0, 1, 4'd1, 32'h0, 32'h0, 32'h12345678);
    @(negedge clk);
    checkFlag("empty_back_idle", bus.busy, 1'b0);
    checkFlag("empty_no_rd_yet", bus.fifo_rd_en, 1'b0);
    @(negedge clk);
    checkFlag("rd_en", bus.fifo_rd_en, 1'b1);
    checkFlag("rd_gnt", bus.rd_gnt, 1'b1);
    checkFlag("rd_wr_en_low", bus.fifo_wr_en, 1'b0);
    applyStimulus(0, 0, 0, 4'd1, 32'h0, 32'h0, 32'h12345678);
    @(negedge clk);
    checkFlag("rd_valid", bus.rd_valid, 1'b1);
    checkOutput("rd_data", bus.rd_data, 32'h12345678);
    checkFlag("rd_gnt_drop", bus.rd_gnt, 1'b0);
    applyStimulus(0, 0, 0, 4'd0, 32'h0, 32'h0, 32'hFFFFFFFF);
    @(negedge clk);
    checkFlag("rd_valid_drop", bus.rd_valid, 1'b0);
    checkOutput("rd_data_hold", bus.rd_data, 32'h12345678);

    // Fairness with all three requesters held
    applyStimulus(1, 1, 1, 4'd4, 32'h11111111, 32'h22222222, 32'h0);
    for (int cyc = 0; cyc < 20 && grantSeq.size() < 4; cyc++) begin
      @(negedge clk);
      checkFlag("fair_exclusive", bus.fifo_wr_en & bus.fifo_rd_en, 1'b0);
      if (bus.wr_gnt0) grantSeq.push_back(0);
      if (bus.wr_gnt1) grantSeq.push_back(1);
      if (bus.rd_gnt)  grantSeq.push_back(2);
    end
    applyStimulus(0, 0, 0, 4'd4, 32'h0, 32'h0, 32'h0);
    checkOutput("fair_count", grantSeq.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < grantSeq.size()) begin
        checkOutput($sformatf("fair_order%0d", i), grantSeq[i], expSeq[i]);
      end
    end
    waitIdle("fair_idle");

    // Reset while a write is being issued
    applyStimulus(1, 0, 0, 4'd2, 32'h0F0F0F0F, 32'h0, 32'h0);
    @(negedge clk);
    checkFlag("midrst_gnt0_before", bus.wr_gnt0, 1'b1);
    #1 reset = 1'b1;
    #1;
    checkFlag("midrst_wr_en", bus.fifo_wr_en, 1'b0);
    checkFlag("midrst_gnt0", bus.wr_gnt0, 1'b0);
    checkFlag("midrst_busy", bus.busy, 1'b0);
    checkOutput("midrst_din", bus.fifo_din, 32'h0);
    applyStimulus(1, 1, 1, 4'd4, 32'h0F0F0F0F, 32'h22222222, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkFlag("postrst_gnt0", bus.wr_gnt0, 1'b1);
    checkFlag("postrst_gnt1", bus.wr_gnt1, 1'b0);
    checkFlag("postrst_rd_gnt", bus.rd_gnt, 1'b0);
    checkOutput("postrst_din", bus.fifo_din, 32'h0F0F0F0F);
    applyStimulus(0, 0, 0, 4'd4, 32'h0, 32'h0, 32'h0);
    waitIdle("postrst_idle");

    // Overfull count: reads only
    applyStimulus(0, 1, 1, 4'd9, 32'h0, 32'h33333333, 32'h5555AAAA);
    rdCount = 0;
    wrCount = 0;
    repeat (9) begin
      @(negedge clk);
      if (bus.rd_gnt) rdCount++;
      if (bus.wr_gnt1 || bus.fifo_wr_en) wrCount++;
    end
    checkOutput("over_rd_grants", rdCount, 32'd3);
    checkOutput("over_wr_grants", wrCount, 32'd0);
    checkOutput("over_rd_data", bus.rd_data, 32'h5555AAAA);
    applyStimulus(0, 0, 0, 4'd0, 32'h0, 32'h0, 32'h0);
    waitIdle("over_idle");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
